// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
//
// Sequences an external turn counter. An accepted command loads the counter
// (cnt_baz) with a turn value and a reload mode. The block then issues
// prescaled ticks (cnt_blrb) until the counter reports expiry (cnt_cwm). Each
// expiry is reported as an event on a valid/ready port. After the event
// handshake, the counter's expiry flag is cleared (cnt_zz1pb, active low).
// Repeat-mode commands then resume ticking; one-shot commands return to IDLE.
//
// Ports
//   sysclk, foo_card_n      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (cmd_ready high only in IDLE)
//   cmd_turn, cmd_repeat    turn value and auto-reload flag, captured on accept
//   cmd_abort               stop request, honoured in LOAD/RUN/ACK
//   presc                   tick divider, one tick every presc+1 RUN cycles
//   cnt_baz, cnt_blrb       counter load strobe and tick strobe
//   cnt_bar, cnt_turn       captured reload mode and turn value (held)
//   cnt_zz1pb               active-low expiry-flag clear
//   cnt_cwm                 expiry flag from the counter
//   evt_valid/evt_ready     event handshake
//   evt_count               saturating expiry count since command accept
//   busy                    high whenever not in IDLE
// -----------------------------------------------------------------------------
module counter_sequencer #(
   parameter int TW = 32,
   parameter int PW = 16
) (
   input  logic          sysclk,
   input  logic          foo_card_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [TW-1:0] cmd_turn,
   input  logic          cmd_repeat,
   input  logic          cmd_abort,
   input  logic [PW-1:0] presc,
   output logic          cnt_baz,
   output logic          cnt_blrb,
   output logic          cnt_bar,
   output logic [TW-1:0] cnt_turn,
   output logic          cnt_zz1pb,
   input  logic          cnt_cwm,
   output logic          evt_valid,
   input  logic          evt_ready,
   output logic [7:0]    evt_count,
   output logic          busy
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_ACK  = 3'd3;
   localparam logic [2:0] S_CLR  = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] turn_q, turn_d;
   logic          repeat_q, repeat_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          abort_q, abort_d;
   logic [7:0]    evt_count_q, evt_count_d;

   logic          cmd_ready_q, busy_q, baz_q, blrb_q, zz1pb_q, evt_valid_q;

   // Next-state and datapath logic.
   // NOTE: every signal assigned here gets a default first so no path leaves
   // it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d     = state_q;
      turn_d      = turn_q;
      repeat_d    = repeat_q;
      presc_d     = presc_q;
      abort_d     = abort_q;
      evt_count_d = evt_count_q;
      pcnt_d      = '0;           // prescaler is cleared outside RUN

      unique case (state_q)
         S_IDLE: begin
            // cmd_ready_q is low on the first cycle after reset release, so a
            // command is only taken once the handshake is actually offered.
            // A zero turn is still accepted, but nothing is captured.
            if (cmd_valid && cmd_ready_q && (cmd_turn != '0)) begin
               turn_d      = cmd_turn;
               repeat_d    = cmd_repeat;
               presc_d     = presc;
               abort_d     = 1'b0;
               evt_count_d = '0;
               state_d     = S_LOAD;
            end
         end

         S_LOAD: begin
            if (cmd_abort) begin
               abort_d = 1'b1;
               state_d = S_CLR;
            end else begin
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            // Abort outranks a same-cycle expiry.
            if (cmd_abort) begin
               abort_d = 1'b1;
               state_d = S_CLR;
            end else if (cnt_cwm) begin
               if (evt_count_q != 8'hFF) begin
                  evt_count_d = evt_count_q + 8'd1;
               end
               state_d = S_ACK;
            end else begin
               pcnt_d = (pcnt_q == presc_q) ? '0 : pcnt_q + 1'b1;
            end
         end

         S_ACK: begin
            // Abort outranks a same-cycle evt_ready; the event is dropped.
            if (cmd_abort) begin
               abort_d = 1'b1;
               state_d = S_CLR;
            end else if (evt_ready) begin
               state_d = S_CLR;
            end
         end

         S_CLR: begin
            state_d = (repeat_q && !abort_q) ? S_RUN : S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state, so each strobe is high in
   // exactly the cycles spent in the matching state. The tick is high in the
   // RUN cycle where the prescaler sits at its terminal value.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge sysclk or negedge foo_card_n) begin
      // NOTE: every register, including captured command fields, has a
      // defined reset value; there are no memory arrays left unreset.
      if (!foo_card_n) begin
         state_q     <= S_IDLE;
         turn_q      <= '0;
         repeat_q    <= 1'b0;
         presc_q     <= '0;
         pcnt_q      <= '0;
         abort_q     <= 1'b0;
         evt_count_q <= '0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         baz_q       <= 1'b0;
         blrb_q      <= 1'b0;
         zz1pb_q     <= 1'b1;
         evt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         turn_q      <= turn_d;
         repeat_q    <= repeat_d;
         presc_q     <= presc_d;
         pcnt_q      <= pcnt_d;
         abort_q     <= abort_d;
         evt_count_q <= evt_count_d;
         cmd_ready_q <= (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE);
         baz_q       <= (state_d == S_LOAD);
         blrb_q      <= (state_d == S_RUN) && (pcnt_d == presc_q);
         zz1pb_q     <= (state_d != S_CLR);
         evt_valid_q <= (state_d == S_ACK);
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign cnt_baz   = baz_q;
   assign cnt_blrb  = blrb_q;
   assign cnt_bar   = repeat_q;
   assign cnt_turn  = turn_q;
   assign cnt_zz1pb = zz1pb_q;
   assign evt_valid = evt_valid_q;
   assign evt_count = evt_count_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_sequencer
//
// Directed bench for counter_sequencer with an attached down-counter model.
// The model loads on cnt_baz and decrements on cnt_blrb. On the tick that
// takes it to zero, it raises cnt_cwm (combinationally, then sticky until
// cnt_zz1pb). In reload mode it then reloads the turn value.
// -----------------------------------------------------------------------------
module tb_counter_sequencer;

   logic        sysclk = 1'b0;
   logic        foo_card_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_turn;
   logic        cmd_repeat;
   logic        cmd_abort;
   logic [15:0] presc;
   logic        cnt_baz;
   logic        cnt_blrb;
   logic        cnt_bar;
   logic [31:0] cnt_turn;
   logic        cnt_zz1pb;
   wire logic   cnt_cwm;
   logic        evt_valid;
   logic        evt_ready;
   logic [7:0]  evt_count;
   logic        busy;

   int checks = 0;
   int errors = 0;

   counter_sequencer #(.TW(32), .PW(16)) dut (
      .sysclk     (sysclk),
      .foo_card_n (foo_card_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_turn   (cmd_turn),
      .cmd_repeat (cmd_repeat),
      .cmd_abort  (cmd_abort),
      .presc      (presc),
      .cnt_baz    (cnt_baz),
      .cnt_blrb   (cnt_blrb),
      .cnt_bar    (cnt_bar),
      .cnt_turn   (cnt_turn),
      .cnt_zz1pb  (cnt_zz1pb),
      .cnt_cwm    (cnt_cwm),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_count  (evt_count),
      .busy       (busy)
   );

   always #5 sysclk = ~sysclk;

   // Counter model
   logic [31:0] m_cnt  = '0;
   logic        m_flag = 1'b0;

   always @(posedge sysclk or negedge foo_card_n) begin
      if (!foo_card_n) begin
         m_cnt  <= '0;
         m_flag <= 1'b0;
      end else begin
         if (!cnt_zz1pb) m_flag <= 1'b0;
         if (cnt_baz) begin
            m_cnt <= cnt_turn;
         end else if (cnt_blrb && (m_cnt != 32'd0)) begin
            if (m_cnt == 32'd1) begin
               m_flag <= 1'b1;
               m_cnt  <= cnt_bar ? cnt_turn : 32'd0;
            end else begin
               m_cnt <= m_cnt - 32'd1;
            end
         end
      end
   end

   assign cnt_cwm = m_flag | (cnt_blrb && (m_cnt == 32'd1));

   // Advance one clock; sample/drive 1 ns after the rising edge.
   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   // Offer a command and wait for it to be taken; returns in the cycle after
   // the accepting edge (LOAD for a non-zero turn).
   task automatic send_cmd(input logic [31:0] t, input logic r, input logic [15:0] p);
      int n;
      cmd_turn = t; cmd_repeat = r; presc = p; cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_wait got %b want 1", cmd_ready); end
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      foo_card_n = 1'b0;
      cmd_valid = 0; cmd_turn = '0; cmd_repeat = 0; cmd_abort = 0; presc = '0; evt_ready = 0;
      repeat (3) @(posedge sysclk);
      #1;
      checks++; if (cnt_baz   !== 1'b0)  begin errors++; $display("FAIL rst_baz got %b want 0", cnt_baz); end
      checks++; if (cnt_blrb  !== 1'b0)  begin errors++; $display("FAIL rst_blrb got %b want 0", cnt_blrb); end
      checks++; if (cnt_bar   !== 1'b0)  begin errors++; $display("FAIL rst_bar got %b want 0", cnt_bar); end
      checks++; if (cnt_turn  !== 32'd0) begin errors++; $display("FAIL rst_turn got %0h want 0", cnt_turn); end
      checks++; if (cnt_zz1pb !== 1'b1)  begin errors++; $display("FAIL rst_zz1pb got %b want 1", cnt_zz1pb); end
      checks++; if (evt_valid !== 1'b0)  begin errors++; $display("FAIL rst_evt_valid got %b want 0", evt_valid); end
      checks++; if (evt_count !== 8'd0)  begin errors++; $display("FAIL rst_evt_count got %0d want 0", evt_count); end
      checks++; if (cmd_ready !== 1'b0)  begin errors++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
      checks++; if (busy      !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      foo_card_n = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early got %b want 0", cmd_ready); end
      tick();
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b want 1", cmd_ready); end
      checks++; if (busy      !== 1'b0) begin errors++; $display("FAIL rel_busy got %b want 0", busy); end
   endtask

   task automatic test_one_shot();
      int cyc, pulses, baz_extra;
      evt_ready = 0;
      send_cmd(32'd3, 1'b0, 16'd0);
      checks++; if (cnt_baz  !== 1'b1)  begin errors++; $display("FAIL os_baz got %b want 1", cnt_baz); end
      checks++; if (cnt_turn !== 32'd3) begin errors++; $display("FAIL os_turn got %0d want 3", cnt_turn); end
      checks++; if (cnt_bar  !== 1'b0)  begin errors++; $display("FAIL os_bar got %b want 0", cnt_bar); end
      checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL os_busy got busy=%b ready=%b want 1/0", busy, cmd_ready); end
      cyc = 0; pulses = 0; baz_extra = 0;
      do begin
         tick(); cyc++;
         if (cnt_blrb === 1'b1) pulses++;
         if (cnt_baz  === 1'b1) baz_extra++;
      end while (evt_valid !== 1'b1 && cyc < 50);
      checks++; if (cyc != 4)       begin errors++; $display("FAIL os_cycles got %0d want 4", cyc); end
      checks++; if (pulses != 3)    begin errors++; $display("FAIL os_blrb got %0d want 3", pulses); end
      checks++; if (baz_extra != 0) begin errors++; $display("FAIL os_baz_once got %0d want 0", baz_extra); end
      checks++; if (evt_count !== 8'd1) begin errors++; $display("FAIL os_evt_count got %0d want 1", evt_count); end
      evt_ready = 1;
      tick();
      evt_ready = 0;
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL os_valid_drop got %b want 0", evt_valid); end
      checks++; if (cnt_zz1pb !== 1'b0) begin errors++; $display("FAIL os_clr got %b want 0", cnt_zz1pb); end
      tick();
      checks++; if (cnt_zz1pb !== 1'b1) begin errors++; $display("FAIL os_clr_end got %b want 1", cnt_zz1pb); end
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL os_idle got ready=%b busy=%b want 1/0", cmd_ready, busy); end
   endtask

   task automatic test_zero_turn();
      int baz_seen;
      send_cmd(32'd0, 1'b0, 16'd0);
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zt_idle got ready=%b busy=%b want 1/0", cmd_ready, busy); end
      baz_seen = (cnt_baz === 1'b1) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cnt_baz === 1'b1 || busy === 1'b1) baz_seen++;
      end
      checks++; if (baz_seen != 0) begin errors++; $display("FAIL zt_no_load got %0d want 0", baz_seen); end
   endtask

   task automatic test_backpressure();
      int cyc, pulses, held;
      evt_ready = 0;
      send_cmd(32'd2, 1'b0, 16'd2);
      presc = 16'd0;   // must not affect the running command
      cyc = 0; pulses = 0;
      do begin
         tick(); cyc++;
         if (cnt_blrb === 1'b1) pulses++;
      end while (evt_valid !== 1'b1 && cyc < 50);
      checks++; if (cyc != 7)    begin errors++; $display("FAIL bp_cycles got %0d want 7", cyc); end
      checks++; if (pulses != 2) begin errors++; $display("FAIL bp_blrb got %0d want 2", pulses); end
      held = 0; pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (evt_valid === 1'b1 && evt_count === 8'd1) held++;
         if (cnt_blrb === 1'b1) pulses++;
      end
      checks++; if (held != 10)  begin errors++; $display("FAIL bp_held got %0d want 10", held); end
      checks++; if (pulses != 0) begin errors++; $display("FAIL bp_ack_blrb got %0d want 0", pulses); end
      evt_ready = 1;
      tick();
      evt_ready = 0;
      checks++; if (cnt_zz1pb !== 1'b0 || evt_valid !== 1'b0) begin errors++; $display("FAIL bp_clr got zz1pb=%b valid=%b want 0/0", cnt_zz1pb, evt_valid); end
      tick();
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got %b want 1", cmd_ready); end
   endtask

   task automatic test_repeat();
      int cyc, pulses, baz_seen;
      evt_ready = 1;
      send_cmd(32'd2, 1'b1, 16'd1);
      checks++; if (cnt_bar !== 1'b1) begin errors++; $display("FAIL rp_bar got %b want 1", cnt_bar); end
      for (int e = 1; e <= 3; e++) begin
         cyc = 0; pulses = 0;
         do begin
            tick(); cyc++;
            if (cnt_blrb === 1'b1) pulses++;
         end while (evt_valid !== 1'b1 && cyc < 50);
         checks++; if (cyc != 5)    begin errors++; $display("FAIL rp_cycles%0d got %0d want 5", e, cyc); end
         checks++; if (pulses != 2) begin errors++; $display("FAIL rp_blrb%0d got %0d want 2", e, pulses); end
         checks++; if (evt_count !== 8'(e)) begin errors++; $display("FAIL rp_count%0d got %0d want %0d", e, evt_count, e); end
         tick();
         checks++; if (cnt_zz1pb !== 1'b0) begin errors++; $display("FAIL rp_clr%0d got %b want 0", e, cnt_zz1pb); end
      end
      tick();                       // first RUN cycle of the next turn
      cmd_abort = 1;
      tick();
      cmd_abort = 0;
      checks++; if (cnt_zz1pb !== 1'b0) begin errors++; $display("FAIL rp_abort_clr got %b want 0", cnt_zz1pb); end
      tick();
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rp_abort_idle got ready=%b busy=%b want 1/0", cmd_ready, busy); end
      baz_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (cnt_baz === 1'b1 || evt_valid === 1'b1) baz_seen++;
      end
      checks++; if (baz_seen != 0) begin errors++; $display("FAIL rp_no_reload got %0d want 0", baz_seen); end
      checks++; if (evt_count !== 8'd3) begin errors++; $display("FAIL rp_final_count got %0d want 3", evt_count); end
      evt_ready = 0;
   endtask

   task automatic test_abort_collision();
      int cyc;
      // Abort in the same cycle as an expiry.
      evt_ready = 0;
      send_cmd(32'd3, 1'b1, 16'd0);
      cyc = 0;
      do begin tick(); cyc++; end while (cnt_cwm !== 1'b1 && cyc < 50);
      cmd_abort = 1;
      tick();
      cmd_abort = 0;
      checks++; if (evt_valid !== 1'b0 || cnt_zz1pb !== 1'b0) begin errors++; $display("FAIL ac1_clr got valid=%b zz1pb=%b want 0/0", evt_valid, cnt_zz1pb); end
      checks++; if (evt_count !== 8'd0) begin errors++; $display("FAIL ac1_count got %0d want 0", evt_count); end
      tick();
      checks++; if (cmd_ready !== 1'b1 || evt_valid !== 1'b0) begin errors++; $display("FAIL ac1_idle got ready=%b valid=%b want 1/0", cmd_ready, evt_valid); end

      // Abort in ACK together with evt_ready.
      send_cmd(32'd2, 1'b1, 16'd0);
      cyc = 0;
      do begin tick(); cyc++; end while (evt_valid !== 1'b1 && cyc < 50);
      checks++; if (evt_count !== 8'd1) begin errors++; $display("FAIL ac2_count got %0d want 1", evt_count); end
      evt_ready = 1; cmd_abort = 1;
      tick();
      evt_ready = 0; cmd_abort = 0;
      checks++; if (evt_valid !== 1'b0 || cnt_zz1pb !== 1'b0) begin errors++; $display("FAIL ac2_clr got valid=%b zz1pb=%b want 0/0", evt_valid, cnt_zz1pb); end
      tick();
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ac2_idle got ready=%b busy=%b want 1/0", cmd_ready, busy); end
      checks++; if (evt_count !== 8'd1) begin errors++; $display("FAIL ac2_count_hold got %0d want 1", evt_count); end
   endtask

   task automatic test_saturation();
      int nev, bad, cyc, expv;
      evt_ready = 1;
      send_cmd(32'd1, 1'b1, 16'd0);
      nev = 0; bad = 0; cyc = 0;
      while (nev < 300 && cyc < 2000) begin
         tick(); cyc++;
         if (evt_valid === 1'b1) begin
            nev++;
            expv = (nev > 255) ? 255 : nev;
            if (evt_count !== 8'(expv)) bad++;
         end
      end
      checks++; if (nev != 300) begin errors++; $display("FAIL sat_events got %0d want 300", nev); end
      checks++; if (bad != 0)   begin errors++; $display("FAIL sat_sequence got %0d bad want 0", bad); end
      checks++; if (evt_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d want 255", evt_count); end
      evt_ready = 0; cmd_abort = 1;
      tick();
      cmd_abort = 0;
      tick();
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL sat_idle got %b want 1", cmd_ready); end
   endtask

   task automatic test_reset_midop();
      int cyc, glitches;
      for (int ph = 0; ph < 2; ph++) begin
         evt_ready = 0;
         if (ph == 0) begin
            send_cmd(32'd5, 1'b0, 16'd3);
            cyc = 0;
            do begin tick(); cyc++; end while (cnt_blrb !== 1'b1 && cyc < 50);
         end else begin
            send_cmd(32'd1, 1'b0, 16'd0);
            cyc = 0;
            do begin tick(); cyc++; end while (evt_valid !== 1'b1 && cyc < 50);
         end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mr%0d_busy_before got %b want 1", ph, busy); end
         #2;
         foo_card_n = 1'b0;
         #1;
         checks++; if (busy !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL mr%0d_hs got busy=%b ready=%b want 0/0", ph, busy, cmd_ready); end
         checks++; if (cnt_zz1pb !== 1'b1 || evt_valid !== 1'b0) begin errors++; $display("FAIL mr%0d_flags got zz1pb=%b valid=%b want 1/0", ph, cnt_zz1pb, evt_valid); end
         checks++; if (cnt_blrb !== 1'b0 || cnt_baz !== 1'b0 || cnt_bar !== 1'b0) begin errors++; $display("FAIL mr%0d_strobes got blrb=%b baz=%b bar=%b want 0", ph, cnt_blrb, cnt_baz, cnt_bar); end
         checks++; if (cnt_turn !== 32'd0 || evt_count !== 8'd0) begin errors++; $display("FAIL mr%0d_values got turn=%0d count=%0d want 0/0", ph, cnt_turn, evt_count); end
         tick(); tick();
         foo_card_n = 1'b1;
         #1;
         checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mr%0d_ready_early got %b want 0", ph, cmd_ready); end
         tick();
         checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mr%0d_ready got %b want 1", ph, cmd_ready); end
         glitches = 0;
         for (int i = 0; i < 5; i++) begin
            tick();
            if (cnt_zz1pb !== 1'b1 || evt_valid !== 1'b0 || busy !== 1'b0) glitches++;
         end
         checks++; if (glitches != 0) begin errors++; $display("FAIL mr%0d_quiet got %0d want 0", ph, glitches); end
      end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_zero_turn();
      test_backpressure();
      test_repeat();
      test_abort_collision();
      test_saturation();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
